// File: rtl/fp_physical_regfile_arb.sv
// FP physical register file with round-robin writeback arbitration, per-preg ready scoreboard
// and optional same-cycle bypass of granted writes onto the rename read ports.
module fp_physical_regfile_arb #(
  parameter int REG_SIZE       = 36,
  parameter int REG_SIZE_WIDTH = 6,
  parameter int XLEN           = 64,
  parameter int NUM_RD         = 6,
  parameter int NUM_WB         = 4,
  parameter int NUM_WR_PORTS   = 2,
  parameter int NUM_ALLOC      = 2,
  parameter int BYPASS         = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_WB-1:0]                   wb_valid_i,
  input  logic [NUM_WB*REG_SIZE_WIDTH-1:0]    wb_addr_i,
  input  logic [NUM_WB*XLEN-1:0]              wb_data_i,
  output logic [NUM_WB-1:0]                   wb_ready_o,
  input  logic [NUM_RD*REG_SIZE_WIDTH-1:0]    rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]              rd_data_o,
  output logic [NUM_RD-1:0]                   rd_ready_o,
  input  logic [NUM_ALLOC-1:0]                alloc_valid_i,
  input  logic [NUM_ALLOC*REG_SIZE_WIDTH-1:0] alloc_addr_i,
  input  logic                                flush_i
);

  localparam int AW    = REG_SIZE_WIDTH;
  localparam int PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  // Handshake: a writeback transfer completes on a rising edge where wb_valid_i[k] and
  // wb_ready_o[k] are both high; a waiting source keeps valid, addr and data stable.

  // P0 and out-of-range addresses never hold state.
  function automatic logic is_live(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < REG_SIZE);
  endfunction

  logic [REG_SIZE-1:0][XLEN-1:0] regs_q, regs_d;
  logic [REG_SIZE-1:0]           ready_q, ready_d;
  logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;

  logic [NUM_WB-1:0]                   grant;
  logic [NUM_WR_PORTS-1:0]             slot_vld;
  logic [NUM_WR_PORTS-1:0][AW-1:0]     slot_addr;
  logic [NUM_WR_PORTS-1:0][XLEN-1:0]   slot_data;
  logic                                dup_wr;

  // Slots are filled in scan order, so a higher slot index is a later grant.
  always_comb begin
    int n_gnt;
    int idx;
    grant     = '0;
    slot_vld  = '0;
    slot_addr = '0;
    slot_data = '0;
    rr_ptr_d  = rr_ptr_q;
    n_gnt     = 0;
    idx       = 0;
    for (int i = 0; i < NUM_WB; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_WB) idx = idx - NUM_WB;
      for (int j = 0; j < NUM_WB; j++) begin
        if (j == idx && !rst && wb_valid_i[j] && n_gnt < NUM_WR_PORTS) begin
          grant[j] = 1'b1;
          for (int s = 0; s < NUM_WR_PORTS; s++) begin
            if (s == n_gnt) begin
              slot_vld[s]  = 1'b1;
              slot_addr[s] = wb_addr_i[j*AW +: AW];
              slot_data[s] = wb_data_i[j*XLEN +: XLEN];
            end
          end
          n_gnt    = n_gnt + 1;
          rr_ptr_d = (j == NUM_WB - 1) ? '0 : PTR_W'(j + 1);
        end
      end
    end
  end

  assign wb_ready_o = grant;

  always_comb begin
    dup_wr = 1'b0;
    for (int s = 0; s < NUM_WR_PORTS; s++) begin
      for (int t = s + 1; t < NUM_WR_PORTS; t++) begin
        if (slot_vld[s] && slot_vld[t] && is_live(slot_addr[s]) &&
            slot_addr[s] == slot_addr[t]) begin
          dup_wr = 1'b1;
        end
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int s = 0; s < NUM_WR_PORTS; s++) begin
      if (slot_vld[s] && is_live(slot_addr[s])) begin
        regs_d[slot_addr[s]] = slot_data[s];
      end
    end
  end

  // Priority, lowest to highest: write sets, alloc clears, flush sets all.
  always_comb begin
    ready_d = ready_q;
    for (int s = 0; s < NUM_WR_PORTS; s++) begin
      if (slot_vld[s] && is_live(slot_addr[s])) begin
        ready_d[slot_addr[s]] = 1'b1;
      end
    end
    for (int a = 0; a < NUM_ALLOC; a++) begin
      if (alloc_valid_i[a] && is_live(alloc_addr_i[a*AW +: AW])) begin
        ready_d[alloc_addr_i[a*AW +: AW]] = 1'b0;
      end
    end
    if (flush_i) ready_d = '1;
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q   <= '0;
      ready_q  <= '1;
      rr_ptr_q <= '0;
    end else begin
      regs_q   <= regs_d;
      ready_q  <= ready_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    rd_data_o  = '0;
    rd_ready_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_addr_i[p*AW +: AW] == '0) begin
        rd_ready_o[p] = 1'b1;
      end else if (is_live(rd_addr_i[p*AW +: AW])) begin
        rd_data_o[p*XLEN +: XLEN] = regs_q[rd_addr_i[p*AW +: AW]];
        rd_ready_o[p]             = ready_q[rd_addr_i[p*AW +: AW]];
        if (BYPASS != 0) begin
          for (int s = 0; s < NUM_WR_PORTS; s++) begin
            if (slot_vld[s] && slot_addr[s] == rd_addr_i[p*AW +: AW]) begin
              rd_data_o[p*XLEN +: XLEN] = slot_data[s];
              rd_ready_o[p]             = 1'b1;
            end
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_WB; k++) begin : g_wb_chk
    a_hold: assert property (@(posedge clk) disable iff (rst)
      (wb_valid_i[k] && !wb_ready_o[k]) |=>
        (wb_valid_i[k] && $stable(wb_addr_i[k*AW +: AW]) &&
         $stable(wb_data_i[k*XLEN +: XLEN])));
    a_no_spurious_ready: assert property (@(posedge clk)
      wb_ready_o[k] |-> wb_valid_i[k]);
  end

  a_no_dup_write: assert property (@(posedge clk) disable iff (rst) !dup_wr);

endmodule

// File: tb/tb_fp_physical_regfile_arb.sv
// Directed bench for fp_physical_regfile_arb: reset state, bypass, round-robin order,
// P0 handling, alloc/flush priority and reset in mid-request.
module tb_fp_physical_regfile_arb;

  logic          clk;
  logic          rst;
  logic [3:0]    wb_valid;
  logic [23:0]   wb_addr;
  logic [255:0]  wb_data;
  logic [3:0]    wb_ready;
  logic [35:0]   rd_addr;
  logic [383:0]  rd_data;
  logic [5:0]    rd_ready;
  logic [1:0]    alloc_valid;
  logic [11:0]   alloc_addr;
  logic          flush;

  int checks = 0;
  int errors = 0;

  fp_physical_regfile_arb dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid_i    (wb_valid),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .wb_ready_o    (wb_ready),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_ready_o    (rd_ready),
    .alloc_valid_i (alloc_valid),
    .alloc_addr_i  (alloc_addr),
    .flush_i       (flush)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic [1:0] k, input logic v, input logic [5:0] a,
                        input logic [63:0] d);
    wb_valid[k]        = v;
    wb_addr[k*6 +: 6]  = a;
    wb_data[k*64 +: 64] = d;
  endtask

  task automatic set_alloc(input logic k, input logic v, input logic [5:0] a);
    alloc_valid[k]       = v;
    alloc_addr[k*6 +: 6] = a;
  endtask

  task automatic read_port(input logic [2:0] p, input logic [5:0] a);
    rd_addr[p*6 +: 6] = a;
  endtask

  task automatic expect_rd(input string tag, input logic [2:0] p, input logic [63:0] d,
                           input logic r);
    check({tag, "_data"}, rd_data[p*64 +: 64], d);
    check({tag, "_rdy"}, {63'd0, rd_ready[p]}, {63'd0, r});
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 4'hF; wb_addr = '0; wb_data = '0;
    rd_addr = '0; alloc_valid = '0; alloc_addr = '0; flush = 1'b0;
    #3;
    check("rst_wb_ready", {60'd0, wb_ready}, 64'd0);
    tick();
    check("rst_wb_ready_edge", {60'd0, wb_ready}, 64'd0);
    wb_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // every preg reads 0 / ready after reset
    for (int g = 0; g < 6; g++) begin
      for (int p = 0; p < 6; p++) read_port(3'(p), 6'(g*6 + p));
      #1;
      for (int p = 0; p < 6; p++) expect_rd($sformatf("rst_p%0d", g*6 + p), 3'(p), 64'd0, 1'b1);
    end
    read_port(0, 6'd40);
    read_port(1, 6'd63);
    #1;
    expect_rd("oob40", 0, 64'd0, 1'b0);
    expect_rd("oob63", 1, 64'd0, 1'b0);
    check("idle_wb_ready", {60'd0, wb_ready}, 64'd0);

    // alloc P5, then source 2 writes it (rr_ptr 0 -> 3)
    set_alloc(0, 1'b1, 6'd5);
    tick();
    set_alloc(0, 1'b0, 6'd0);
    read_port(0, 6'd5);
    #1;
    expect_rd("alloc_p5", 0, 64'd0, 1'b0);
    set_wb(2, 1'b1, 6'd5, 64'h3FF0000000000000);
    #1;
    check("p5_grant", {60'd0, wb_ready}, 64'h4);
    expect_rd("p5_bypass", 0, 64'h3FF0000000000000, 1'b1);
    tick();
    set_wb(2, 1'b0, 6'd0, 64'd0);
    #1;
    expect_rd("p5_array", 0, 64'h3FF0000000000000, 1'b1);

    // source 1 alone: rr_ptr 3 -> 2
    set_wb(1, 1'b1, 6'd10, 64'h11);
    #1;
    check("s1_grant", {60'd0, wb_ready}, 64'h2);
    tick();
    set_wb(1, 1'b0, 6'd0, 64'd0);

    // only source 3 with rr_ptr 2: granted alone, rr_ptr -> 0
    set_wb(3, 1'b1, 6'd11, 64'h33);
    #1;
    check("s3_alone_grant", {60'd0, wb_ready}, 64'h8);
    tick();
    set_wb(3, 1'b0, 6'd0, 64'd0);

    // all four valid continuously from rr_ptr 0
    for (int k = 0; k < 4; k++) set_wb(2'(k), 1'b1, 6'(12 + k), 64'(32'h100 + k));
    #1;
    check("rr_cyc0", {60'd0, wb_ready}, 64'h3);
    tick();
    set_wb(0, 1'b1, 6'd16, 64'h200);
    set_wb(1, 1'b1, 6'd17, 64'h201);
    #1;
    check("rr_cyc1", {60'd0, wb_ready}, 64'hC);
    tick();
    set_wb(2, 1'b1, 6'd18, 64'h202);
    set_wb(3, 1'b1, 6'd19, 64'h203);
    #1;
    check("rr_cyc2", {60'd0, wb_ready}, 64'h3);
    tick();
    set_wb(0, 1'b0, 6'd0, 64'd0);
    set_wb(1, 1'b0, 6'd0, 64'd0);
    #1;
    check("rr_cyc3", {60'd0, wb_ready}, 64'hC);
    tick();
    set_wb(2, 1'b0, 6'd0, 64'd0);
    set_wb(3, 1'b0, 6'd0, 64'd0);
    for (int p = 0; p < 6; p++) read_port(3'(p), 6'(12 + p));
    #1;
    expect_rd("p12", 0, 64'h100, 1'b1);
    expect_rd("p13", 1, 64'h101, 1'b1);
    expect_rd("p14", 2, 64'h102, 1'b1);
    expect_rd("p15", 3, 64'h103, 1'b1);
    expect_rd("p16", 4, 64'h200, 1'b1);
    expect_rd("p17", 5, 64'h201, 1'b1);
    read_port(0, 6'd18);
    read_port(1, 6'd19);
    read_port(2, 6'd10);
    read_port(3, 6'd11);
    #1;
    expect_rd("p18_held", 0, 64'h202, 1'b1);
    expect_rd("p19_held", 1, 64'h203, 1'b1);
    expect_rd("p10", 2, 64'h11, 1'b1);
    expect_rd("p11", 3, 64'h33, 1'b1);

    // write to P0 is accepted and discarded (rr_ptr 0 -> 1)
    set_wb(0, 1'b1, 6'd0, 64'hDEAD);
    read_port(0, 6'd0);
    #1;
    check("p0_grant", {60'd0, wb_ready}, 64'h1);
    expect_rd("p0_same", 0, 64'd0, 1'b1);
    tick();
    set_wb(0, 1'b0, 6'd0, 64'd0);
    #1;
    expect_rd("p0_after", 0, 64'd0, 1'b1);

    // alloc + write + flush on P7; flush also overrides an alloc of P8 (rr_ptr 1 -> 2)
    set_alloc(1, 1'b1, 6'd7);
    set_alloc(0, 1'b1, 6'd8);
    set_wb(1, 1'b1, 6'd7, 64'h55);
    flush = 1'b1;
    read_port(0, 6'd7);
    read_port(1, 6'd8);
    #1;
    check("flush_grant", {60'd0, wb_ready}, 64'h2);
    expect_rd("p7_bypass", 0, 64'h55, 1'b1);
    tick();
    set_alloc(1, 1'b0, 6'd0);
    set_alloc(0, 1'b0, 6'd0);
    set_wb(1, 1'b0, 6'd0, 64'd0);
    flush = 1'b0;
    #1;
    expect_rd("p7_flush", 0, 64'h55, 1'b1);
    expect_rd("p8_flush", 1, 64'd0, 1'b1);

    // same without flush: alloc wins the ready bit, write still lands
    set_alloc(0, 1'b1, 6'd7);
    set_wb(1, 1'b1, 6'd7, 64'h77);
    #1;
    check("noflush_grant", {60'd0, wb_ready}, 64'h2);
    tick();
    set_alloc(0, 1'b0, 6'd0);
    set_wb(1, 1'b0, 6'd0, 64'd0);
    #1;
    expect_rd("p7_alloc_wins", 0, 64'h77, 1'b0);

    // lone flush restores readiness without touching data
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    expect_rd("p7_flush_only", 0, 64'h77, 1'b1);

    // reset in the middle of a pending request
    set_wb(2, 1'b1, 6'd20, 64'hAB);
    read_port(2, 6'd20);
    read_port(3, 6'd5);
    #1;
    check("pre_rst_grant", {60'd0, wb_ready}, 64'h4);
    rst = 1'b1;
    #1;
    check("mid_rst_wb_ready", {60'd0, wb_ready}, 64'd0);
    expect_rd("p5_cleared", 3, 64'd0, 1'b1);
    tick();
    set_wb(2, 1'b0, 6'd0, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    expect_rd("p20_dropped", 2, 64'd0, 1'b1);
    check("post_rst_wb_ready", {60'd0, wb_ready}, 64'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_physical_regfile_arb.md
Name: fp_physical_regfile_arb

Overview:
Parametrised floating-point physical register file with an integrated writeback arbiter and a per-register ready scoreboard. Any number of FP writeback sources (FALUs, LSU, fdiv/sqrt, future units) request with a valid/ready handshake. A round-robin arbiter grants up to NUM_WR_PORTS of them per cycle. Rename-stage read ports return operand data plus a ready bit, with optional same-cycle writeback bypass. The block sits between the FP execution writeback buses and the RCU issue/rename logic.

Parameters:
REG_SIZE, 36, number of physical FP registers; P0 is hardwired zero.
REG_SIZE_WIDTH, 6, physical register address width; must be at least clog2(REG_SIZE).
XLEN, 64, data width.
NUM_RD, 6, number of read ports.
NUM_WB, 4, number of writeback sources.
NUM_WR_PORTS, 2, maximum array writes per cycle; must satisfy 1 <= NUM_WR_PORTS <= NUM_WB.
NUM_ALLOC, 2, number of rename allocation ports.
BYPASS, 1, when 1, read ports forward same-cycle granted writes.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wb_valid_i  in  NUM_WB  writeback request per source
wb_addr_i  in  NUM_WB*REG_SIZE_WIDTH  destination preg; source k occupies slice k
wb_data_i  in  NUM_WB*XLEN  writeback data; source k occupies slice k
wb_ready_o  out  NUM_WB  grant; a transfer occurs when valid and ready are both high
rd_addr_i  in  NUM_RD*REG_SIZE_WIDTH  read addresses
rd_data_o  out  NUM_RD*XLEN  read data
rd_ready_o  out  NUM_RD  scoreboard ready bit of the addressed preg
alloc_valid_i  in  NUM_ALLOC  rename allocates a new destination preg
alloc_addr_i  in  NUM_ALLOC*REG_SIZE_WIDTH  allocated preg
flush_i  in  1  pipeline flush; marks every preg ready

Behaviour:
- Reset (asynchronous, on rst high):
  - all registers = 0
  - all ready bits = 1
  - rr_ptr = 0
  - wb_ready_o = 0 while rst is asserted
- Arbitration is combinational within the cycle:
  - scan sources in order rr_ptr, rr_ptr+1, ... modulo NUM_WB
  - grant the first NUM_WR_PORTS sources with wb_valid_i = 1
  - wb_ready_o[k] = 1 only for granted sources; wb_ready_o[k] never asserts without wb_valid_i[k]
  - an ungranted source holds valid, addr and data stable until granted; data changes while waiting are a protocol violation and are asserted against
- rr_ptr update at the clock edge:
  - if any grant: rr_ptr <= (index of last granted source + 1) mod NUM_WB
  - otherwise rr_ptr is unchanged
  - a continuously requesting source is therefore granted within ceil(NUM_WB/NUM_WR_PORTS) cycles
- Write:
  - on the clock edge, every granted transfer writes registers[addr] <= data and sets ready[addr] <= 1
  - latency: data is visible on the read port the cycle after the grant, or in the same cycle when BYPASS = 1
  - addr 0: the transfer is accepted (handshake completes) but registers[0] stays 0
- Two granted writes to the same address in one cycle:
  - illegal; covered by an assertion
  - RTL result: the later-in-scan-order grant wins
- Allocation: alloc_valid_i[j] with a nonzero address clears ready[addr] at the edge.
  - Allocation to P0 is ignored.
  - Allocation and a write to the same preg in the same cycle: the write data is stored, but the ready bit ends at 0 (alloc has priority).
- flush_i: sets every ready bit to 1 at the edge.
  - Overrides alloc in the same cycle.
  - Writes in the same cycle still update data.
- Read (combinational):
  - rd_data_o = registers[addr], rd_ready_o = ready[addr]
  - addr 0: data 0, ready 1
  - BYPASS = 1 and addr matches a granted write this cycle (addr != 0): return that write's data, ready = 1; if several match, the later grant in scan order wins
  - addresses >= REG_SIZE: data 0, ready 0
- Reset asserted mid-arbitration drops in-flight requests. Sources must re-present them after reset.

Test Plan:
- Reset, then read all pregs -> data 0, ready 1 on every read port; wb_ready_o = 0.
- Alloc P5; next cycle read P5 -> ready 0. Source 2 writes 0x3FF0000000000000 to P5 -> with BYPASS the same cycle shows that data and ready 1; the following cycle the array holds it with ready 1.
- All 4 sources valid continuously with rr_ptr = 0:
  - cycle 0 grants 0,1
  - cycle 1 grants 2,3
  - cycle 2 grants 0,1
  - an ungranted source holds its data and it lands later, unchanged.
- Only source 3 valid, rr_ptr = 2 -> source 3 granted alone; rr_ptr becomes 0.
- Write 0xDEAD to P0 -> ready 1 returned, a later read of P0 returns 0.
- Same cycle: alloc P7, write P7 = 0x55, flush_i = 1 -> next cycle P7 data 0x55, ready 1. Repeat without flush -> P7 data 0x55, ready 0.
